mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, variable-latency memory between the core's instruction-fetch port and data port. It sits between the pipelined RISC core and the unified memory. It latches one request at a time, drives a req/ack transaction on the memory side, and returns the read data with a one-cycle valid pulse to the requester that won. Data accesses have priority; an optional ageing counter prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_age_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int AW_DEF       = 32;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating fetch wait counter; expired_o flags that the fetch has waited MAX_WAIT cycles.
module arb_age_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory between the fetch and data ports, data first.
// Optional fetch ageing is enabled by defining ARB_AGE_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_address,
  output logic [DW-1:0]   i_data_read,
  output logic            i_data_valid,
  input  logic            d_req,
  input  logic [AW-1:0]   d_address,
  input  logic [DW-1:0]   d_data_write,
  input  logic [DW/8-1:0] d_data_wstrb,
  input  logic            d_write_enable,
  output logic [DW-1:0]   d_data_read,
  output logic            d_data_valid,
  output logic            m_req,
  output logic [AW-1:0]   m_address,
  output logic [DW-1:0]   m_data_write,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_write_enable,
  input  logic [DW-1:0]   m_data_read,
  input  logic            m_ack,
  output logic            busy
);

  arb_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic              we_q, we_d;
  logic [DW-1:0]     irdata_q, irdata_d;
  logic [DW-1:0]     drdata_q, drdata_d;
  logic              ivld_q, ivld_d;
  logic              dvld_q, dvld_d;
  logic              grant_any;
  logic              grant_sel;
  logic              age_win;

`ifdef ARB_AGE_EN
  arb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk       (clk),
    .rst_n     (reset_n),
    .inc_i     (i_req && (state_q != GRANT_I)),
    .clr_i     ((state_q == IDLE) && (state_d == GRANT_I)),
    .expired_o (age_win)
  );
`else
  // A zero threshold would let fetch always outrank data; legal thresholds give strict data priority.
  assign age_win = (MAX_WAIT == 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
    ivld_d    = 1'b0;
    dvld_d    = 1'b0;
    grant_any = 1'b0;
    grant_sel = PORT_D;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || age_win)) begin
          grant_any = 1'b1;
          grant_sel = PORT_I;
        end else if (d_req) begin
          grant_any = 1'b1;
          grant_sel = PORT_D;
        end
        if (grant_any && (grant_sel == PORT_I)) begin
          state_d = GRANT_I;
          addr_d  = i_address;
          wstrb_d = '0;
          we_d    = 1'b0;
        end else if (grant_any) begin
          state_d = GRANT_D;
          addr_d  = d_address;
          wdata_d = d_data_write;
          // Loads never carry strobes, whatever the core leaves on the strobe lines.
          wstrb_d = d_write_enable ? d_data_wstrb : '0;
          we_d    = d_write_enable;
        end
      end
      GRANT_I: begin
        if (m_ack) begin
          irdata_d = m_data_read;
          ivld_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      GRANT_D: begin
        if (m_ack) begin
          drdata_d = m_data_read;
          dvld_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      ivld_q   <= 1'b0;
      dvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      we_q     <= we_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      ivld_q   <= ivld_d;
      dvld_q   <= dvld_d;
    end
  end

  // Decoded straight from the state register so it falls the moment reset asserts.
  assign m_req          = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign m_address      = addr_q;
  assign m_data_write   = wdata_q;
  assign m_wstrb        = wstrb_q;
  assign m_write_enable = we_q;
  assign i_data_read    = irdata_q;
  assign i_data_valid   = ivld_q;
  assign d_data_read    = drdata_q;
  assign d_data_valid   = dvld_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expectations for the starvation case follow ARB_AGE_EN.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] i_data_read;
  logic        i_data_valid;
  logic        d_req;
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic [3:0]  d_data_wstrb;
  logic        d_write_enable;
  logic [31:0] d_data_read;
  logic        d_data_valid;
  logic        m_req;
  logic [31:0] m_address;
  logic [31:0] m_data_write;
  logic [3:0]  m_wstrb;
  logic        m_write_enable;
  logic [31:0] m_data_read;
  logic        m_ack;
  logic        busy;

  mem_port_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req          (i_req),
    .i_address      (i_address),
    .i_data_read    (i_data_read),
    .i_data_valid   (i_data_valid),
    .d_req          (d_req),
    .d_address      (d_address),
    .d_data_write   (d_data_write),
    .d_data_wstrb   (d_data_wstrb),
    .d_write_enable (d_write_enable),
    .d_data_read    (d_data_read),
    .d_data_valid   (d_data_valid),
    .m_req          (m_req),
    .m_address      (m_address),
    .m_data_write   (m_data_write),
    .m_wstrb        (m_wstrb),
    .m_write_enable (m_write_enable),
    .m_data_read    (m_data_read),
    .m_ack          (m_ack),
    .busy           (busy)
  );

`ifdef ARB_AGE_EN
  localparam int STV_ND    = 2;
  localparam int STV_DROP  = 6;
  localparam int STV_GRANT = 5;
`else
  localparam int STV_ND    = 10;
  localparam int STV_DROP  = 20;
  localparam int STV_GRANT = 21;
`endif
  localparam int STV_VALID = STV_GRANT + 1;

  typedef struct packed {
    logic        port_d;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  bit        mem_en   = 0;
  int        ack_lat  = 0;
  int        wcnt     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'hDEADBEEF ^ (a - 32'h40);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic port_d, input logic [31:0] addr);
    sb_entry_t e;
    e.port_d = port_d;
    e.data   = mem_val(addr);
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory model: ack ack_lat cycles after m_req first appears.
  initial begin
    m_ack       = 1'b0;
    m_data_read = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        m_ack = 1'b0;
        if (m_req) begin
          if (wcnt == ack_lat) begin
            m_ack       = 1'b1;
            m_data_read = mem_val(m_address);
            wcnt        = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Completion monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && (i_data_valid || d_data_valid)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_valid", 64'({i_data_valid, d_data_valid}), 64'd0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check_eq("sb_port", 64'({d_data_valid, i_data_valid}), e.port_d ? 64'd2 : 64'd1);
        check_eq("sb_data", 64'(d_data_valid ? d_data_read : i_data_read), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_address = '0;
    d_req = 1'b0; d_address = '0; d_data_write = '0; d_data_wstrb = '0; d_write_enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_req", 64'(m_req), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_m_address", 64'(m_address), 64'd0);
    check_eq("rst_m_wstrb_we", 64'({m_wstrb, m_write_enable}), 64'd0);
    check_eq("rst_valids", 64'({i_data_valid, d_data_valid}), 64'd0);
    check_eq("rst_rdata", 64'({i_data_read, d_data_read}), 64'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Reset mid-transaction: load from 0x100 aborted while granted.
    d_req = 1'b1; d_address = 32'h100; d_data_wstrb = 4'hF; d_write_enable = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("mid_granted_m_req", 64'(m_req), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_m_req", 64'(m_req), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_m_outs", 64'({m_address, m_wstrb, m_write_enable}), 64'd0);
    check_eq("mid_rst_m_wdata", 64'(m_data_write), 64'd0);
    d_req = 1'b0; d_data_wstrb = '0;
    next_cycle();
    reset_n = 1'b1;
    m_ack = 1'b1; m_data_read = 32'hBAD0BAD0;
    @(negedge clk);
    check_eq("late_ack_busy", 64'(busy), 64'd0);
    next_cycle();
    m_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_d_valid", 64'(d_data_valid), 64'd0);
    check_eq("late_ack_d_rdata", 64'(d_data_read), 64'd0);

    // Single fetch, zero-wait memory.
    mem_en = 1; ack_lat = 0;
    next_cycle();
    i_req = 1'b1; i_address = 32'h40;
    sb_push(1'b0, 32'h40);
    @(negedge clk);
    check_eq("f_c0_busy", 64'(busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check_eq("f_c1_m_req", 64'(m_req), 64'd1);
    check_eq("f_c1_m_address", 64'(m_address), 64'h40);
    check_eq("f_c1_we_strb", 64'({m_wstrb, m_write_enable}), 64'd0);
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    check_eq("f_c2_valid", 64'(i_data_valid), 64'd1);
    check_eq("f_c2_rdata", 64'(i_data_read), 64'hDEADBEEF);
    check_eq("f_c2_busy", 64'(busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check_eq("f_c3_valid_pulse", 64'(i_data_valid), 64'd0);
    check_eq("f_c3_rdata_hold", 64'(i_data_read), 64'hDEADBEEF);

    // Store with strobes, ack three cycles after the request reaches memory.
    ack_lat = 3;
    next_cycle();
    d_req = 1'b1; d_address = 32'h104; d_write_enable = 1'b1;
    d_data_wstrb = 4'b1100; d_data_write = 32'h12345678;
    sb_push(1'b1, 32'h104);
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) begin
        d_req = 1'b0; d_write_enable = 1'b0; d_data_wstrb = '0;
      end
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        check_eq("st_m_req", 64'(m_req), 64'd1);
        check_eq("st_m_wstrb", 64'(m_wstrb), 64'hC);
        check_eq("st_m_we", 64'(m_write_enable), 64'd1);
        check_eq("st_d_valid_early", 64'(d_data_valid), 64'd0);
      end
      if (c == 1) begin
        check_eq("st_m_address", 64'(m_address), 64'h104);
        check_eq("st_m_wdata", 64'(m_data_write), 64'h12345678);
      end
      if (c == 5) begin
        check_eq("st_d_valid", 64'(d_data_valid), 64'd1);
        check_eq("st_i_rdata_hold", 64'(i_data_read), 64'hDEADBEEF);
      end
      next_cycle();
    end

    // Simultaneous requests: data first, fetch right after.
    ack_lat = 0;
    i_req = 1'b1; i_address = 32'h80;
    d_req = 1'b1; d_address = 32'h200; d_write_enable = 1'b0; d_data_wstrb = 4'hF;
    sb_push(1'b1, 32'h200);
    sb_push(1'b0, 32'h80);
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) begin
        d_req = 1'b0; d_data_wstrb = '0;
      end
      if (c == 4) i_req = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check_eq("sim_c1_addr", 64'(m_address), 64'h200);
        check_eq("sim_c1_load_strb", 64'(m_wstrb), 64'd0);
      end
      if (c == 2) check_eq("sim_c2_d_valid", 64'(d_data_valid), 64'd1);
      if (c == 3) check_eq("sim_c3_addr", 64'({m_req, m_address}), 64'h1_0000_0080);
      if (c == 4) check_eq("sim_c4_i_valid", 64'(i_data_valid), 64'd1);
      next_cycle();
    end

    // Stray ack while idle.
    mem_en = 0;
    m_ack = 1'b1; m_data_read = 32'h55AA55AA;
    @(negedge clk);
    check_eq("stray_busy", 64'(busy), 64'd0);
    next_cycle();
    m_ack = 1'b0;
    @(negedge clk);
    check_eq("stray_state", 64'({busy, m_req}), 64'd0);
    check_eq("stray_valids", 64'({i_data_valid, d_data_valid}), 64'd0);
    check_eq("stray_i_rdata", 64'(i_data_read), 64'(mem_val(32'h80)));
    next_cycle();

    // Starvation: data held high, fetch waits for ageing or for data to go quiet.
    mem_en = 1; ack_lat = 0;
    i_req = 1'b1; i_address = 32'h44;
    d_req = 1'b1; d_address = 32'h300; d_write_enable = 1'b0;
    for (int k = 0; k < STV_ND; k++) sb_push(1'b1, 32'h300);
    sb_push(1'b0, 32'h44);
    for (int c = 0; c <= STV_VALID; c++) begin
      if (c == STV_DROP) d_req = 1'b0;
      if (c == STV_VALID) i_req = 1'b0;
      @(negedge clk);
      if ((c % 2 == 1) && (c < STV_GRANT))
        check_eq("stv_d_grant", 64'({m_req, m_address}), 64'h1_0000_0300);
      if (c == STV_GRANT)
        check_eq("stv_i_grant", 64'({m_req, m_address}), 64'h1_0000_0044);
      if (c == STV_VALID)
        check_eq("stv_i_valid", 64'(i_data_valid), 64'd1);
      next_cycle();
    end

    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("end_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
